// File: rtl/nand3_bist_ctrl.sv
// BIST sequencer for a bank of NAND3 cells sharing one 3-bit test bus.
// Walks all 8 vectors, waits SETTLE cycles per vector, then scores every cell output.
module nand3_bist_ctrl #(
   parameter int NCELLS = 8,
   parameter int SETTLE = 2,
   parameter int ERRW   = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   input  logic              ABORT,
   input  logic [NCELLS-1:0] Y_I,
   output logic [2:0]        VEC_O,
   output logic              BUSY,
   output logic              DONE,
   output logic              PASS,
   output logic [ERRW-1:0]   ERR_CNT,
   output logic [NCELLS-1:0] FAIL_MASK,
   output logic [2:0]        FIRST_FAIL_VEC,
   output logic              FIRST_FAIL_VALID
);

   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int PW = $clog2(NCELLS + 1);
   localparam int SW = ((ERRW > PW) ? ERRW : PW) + 1;
   localparam logic [ERRW-1:0] ERR_MAX = '1;
   localparam logic [CW-1:0]   CNT_RELOAD = CW'(SETTLE - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_SAMPLE,
      ST_FINISH
   } state_t;

   state_t              state, state_nxt;
   logic [CW-1:0]       cnt, cnt_nxt;
   logic [2:0]          vec_nxt, ffv_nxt;
   logic                ffvalid_nxt, pass_nxt;
   logic [ERRW-1:0]     err_nxt;
   logic [NCELLS-1:0]   mask_nxt;
   logic [NCELLS-1:0]   mism;
   logic [PW-1:0]       pop;
   logic [SW-1:0]       sum;
   logic [ERRW-1:0]     err_sat;

   // Every cell sees the same vector, so the expected value is one bit fanned out.
   always_comb begin
      mism = Y_I ^ {NCELLS{~&VEC_O}};
      pop  = '0;
      for (int i = 0; i < NCELLS; i++) begin
         pop = pop + PW'(mism[i]);
      end
      sum     = SW'(ERR_CNT) + SW'(pop);
      err_sat = (sum > SW'(ERR_MAX)) ? ERR_MAX : sum[ERRW-1:0];
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      vec_nxt     = VEC_O;
      err_nxt     = ERR_CNT;
      mask_nxt    = FAIL_MASK;
      ffv_nxt     = FIRST_FAIL_VEC;
      ffvalid_nxt = FIRST_FAIL_VALID;
      pass_nxt    = PASS;
      case (state)
         ST_IDLE: begin
            if (START) begin
               vec_nxt     = 3'd0;
               cnt_nxt     = CNT_RELOAD;
               err_nxt     = '0;
               mask_nxt    = '0;
               ffv_nxt     = 3'd0;
               ffvalid_nxt = 1'b0;
               pass_nxt    = 1'b0;
               state_nxt   = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (ABORT) begin
               pass_nxt  = 1'b0;
               state_nxt = ST_IDLE;
            end else if (cnt == '0) begin
               state_nxt = ST_SAMPLE;
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         ST_SAMPLE: begin
            // The sample is scored even when ABORT arrives in the same cycle.
            mask_nxt = FAIL_MASK | mism;
            err_nxt  = err_sat;
            if ((mism != '0) && !FIRST_FAIL_VALID) begin
               ffv_nxt     = VEC_O;
               ffvalid_nxt = 1'b1;
            end
            if (ABORT) begin
               pass_nxt  = 1'b0;
               state_nxt = ST_IDLE;
            end else if (VEC_O == 3'd7) begin
               pass_nxt  = ((FAIL_MASK | mism) == '0);
               state_nxt = ST_FINISH;
            end else begin
               vec_nxt   = VEC_O + 3'd1;
               cnt_nxt   = CNT_RELOAD;
               state_nxt = ST_WAIT;
            end
         end
         ST_FINISH: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state            <= ST_IDLE;
         cnt              <= '0;
         VEC_O            <= 3'd0;
         PASS             <= 1'b0;
         ERR_CNT          <= '0;
         FAIL_MASK        <= '0;
         FIRST_FAIL_VEC   <= 3'd0;
         FIRST_FAIL_VALID <= 1'b0;
      end else begin
         state            <= state_nxt;
         cnt              <= cnt_nxt;
         VEC_O            <= vec_nxt;
         PASS             <= pass_nxt;
         ERR_CNT          <= err_nxt;
         FAIL_MASK        <= mask_nxt;
         FIRST_FAIL_VEC   <= ffv_nxt;
         FIRST_FAIL_VALID <= ffvalid_nxt;
      end
   end

   assign BUSY = (state == ST_WAIT) || (state == ST_SAMPLE);
   assign DONE = (state == ST_FINISH);

endmodule

// File: doc/nand3_bist_ctrl.md
Name: nand3_bist_ctrl

Overview:
Built-in self-test sequencer for a bank of NCELLS NAND3X1 cells whose A/B/C inputs share one 3-bit test bus. On START it walks all 8 input vectors, waits a programmable settle time after each one, then compares every cell output against the NAND3 truth value. It accumulates per-cell failure flags, a saturating mismatch count and the first failing vector. It sits beside the cell bank in the test wrapper and is driven by the chip test controller through a START/DONE handshake.

Parameters:
NCELLS, 8, number of NAND3 cells in the bank (1..32)
SETTLE, 2, cycles each vector is held before sampling (>=1)
ERRW, 8, width of the mismatch counter (>=1)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous reset, active-high
START  in  1  begin test run; honoured only in IDLE
ABORT  in  1  stop the run in progress; honoured only in WAIT/SAMPLE
Y_I  in  NCELLS  cell outputs; bit i is cell i
VEC_O  out  3  test vector broadcast to cells; A=VEC_O[2], B=VEC_O[1], C=VEC_O[0]
BUSY  out  1  high in WAIT and SAMPLE
DONE  out  1  one-cycle pulse in FINISH
PASS  out  1  run completed with zero mismatches
ERR_CNT  out  ERRW  total mismatching cell-samples, saturating
FAIL_MASK  out  NCELLS  sticky per-cell fail flags
FIRST_FAIL_VEC  out  3  vector of the first mismatch in the run
FIRST_FAIL_VALID  out  1  FIRST_FAIL_VEC holds a captured value

Behaviour:
- Clocking: single clock CLK; RST is synchronous and active-high. Y_I is in the CLK domain and has no synchronizer. SETTLE covers cell propagation.
- Reset values: state IDLE; VEC_O=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FAIL_MASK=0, FIRST_FAIL_VEC=0, FIRST_FAIL_VALID=0. A reset mid-run takes effect at the next edge, with no DONE.
- States: IDLE, WAIT, SAMPLE, FINISH.
- IDLE + START:
  - VEC_O<=0, settle counter<=SETTLE-1.
  - Clear ERR_CNT, FAIL_MASK, PASS, FIRST_FAIL_VEC and FIRST_FAIL_VALID.
  - Next state WAIT.
- WAIT: if counter==0, go to SAMPLE; else decrement. WAIT lasts exactly SETTLE cycles.
- SAMPLE:
  - expected = ~(VEC_O[2]&VEC_O[1]&VEC_O[0]), replicated across NCELLS.
  - mism = Y_I ^ expected.
  - FAIL_MASK |= mism.
  - ERR_CNT += popcount(mism), clamped at 2^ERRW-1.
  - If mism!=0 and !FIRST_FAIL_VALID: FIRST_FAIL_VEC<=VEC_O, FIRST_FAIL_VALID<=1.
  - If VEC_O==7, go to FINISH. Otherwise VEC_O++, reload counter, go to WAIT.
- FINISH: DONE=1 and PASS<=(no mismatch in the whole run) for this cycle; next state IDLE.
- Timing: START sampled at edge 0 means BUSY=1 on cycles 1..8*(SETTLE+1) and DONE on cycle 8*(SETTLE+1)+1. With SETTLE=2, DONE is on cycle 25.
- End of run: VEC_O holds 7 after the run and stays there until the next START.
- Results: all result outputs hold until the next START or RST.
- START handling: START in WAIT, SAMPLE or FINISH is ignored; it is not queued.
- ABORT:
  - In WAIT or SAMPLE: IDLE at the next edge, no DONE, PASS=0.
  - Results accumulated so far are retained. A SAMPLE-cycle ABORT still applies that sample's update.
  - ABORT in IDLE or FINISH is ignored.
  - ABORT and START together in IDLE: START wins.
- Priority: RST > ABORT > normal sequencing.

Test Plan:
- All cells good (bench models Y_I=NAND3(VEC_O) per cell), SETTLE=2, START pulse -> BUSY on cycles 1..24, DONE on cycle 25, PASS=1, ERR_CNT=0, FAIL_MASK=0x00, FIRST_FAIL_VALID=0.
- Cell 3 stuck-at-1 -> mismatch only at vector 7 -> ERR_CNT=1, FAIL_MASK=0x08, FIRST_FAIL_VEC=7, FIRST_FAIL_VALID=1, PASS=0.
- Cells 0 and 5 stuck-at-0 -> mismatches on vectors 0..6 -> ERR_CNT=14, FAIL_MASK=0x21, FIRST_FAIL_VEC=0, PASS=0.
- ERRW=3, all 8 cells stuck-at-0 -> 56 raw mismatches -> ERR_CNT saturates at 7, FAIL_MASK=0xFF.
- ABORT on cycle 10 -> BUSY=0 from cycle 11, no DONE, PASS=0. A new START then produces a full clean run with DONE 25 cycles later and PASS=1.
- START re-pulsed on cycle 5 -> ignored, DONE still on cycle 25. RST on cycle 12 -> all outputs 0 and state IDLE at cycle 13, no DONE.
